down_timer_scheduler: RTL and testbench
=======================================

DOWN_TIMER_SCHEDULER -- requirements
Module: down_timer_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, width of the shared down counter and of each load value.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port req, input, NREQ, level request per requester; bit i is requester i.
REQ-006 SHALL have port load_val, input, NREQ*WIDTH, start value per requester; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 SHALL have port abort, input, 1, terminates the active countdown without completion.
REQ-008 SHALL have port gnt, output, NREQ, one-hot owner of the counter; all-zero when idle.
REQ-009 SHALL have port busy, output, 1, high in states COUNT and DONE.
REQ-010 SHALL have port count, output, WIDTH, current shared counter value.
REQ-011 SHALL have port done, output, NREQ, one-cycle one-hot completion pulse to the owner.
REQ-012 SHALL have port pause, input, 1, present only when PAUSE_EN is defined.

Function
REQ-013 SHALL implement states IDLE, COUNT and DONE, all transitions on the rising clk edge.
REQ-014 In IDLE with req nonzero, SHALL grant the lowest-index requesting bit at or above the round-robin pointer, wrapping modulo NREQ.
REQ-015 At the grant edge, SHALL set gnt one-hot, load count from the winner's load_val slice and enter COUNT.
REQ-016 In COUNT with count nonzero, SHALL decrement count by 1 per cycle (unsigned, WIDTH bits).
REQ-017 In COUNT with count zero, SHALL enter DONE and assert done for the owner for exactly one cycle.
REQ-018 From DONE, SHALL return to IDLE on the next edge, clear gnt and done, and set the pointer to owner+1 mod NREQ.
REQ-019 Latency: with load value N, done SHALL be high during cycle N+1 after the grant edge; load value 0 gives done one cycle after the grant.
REQ-020 count SHALL never wrap from 0 to all-ones through decrementing.
REQ-021 req SHALL be sampled only in IDLE; req changes during COUNT or DONE SHALL be ignored, and the owner's request is not re-sampled until IDLE.
REQ-022 In COUNT, abort SHALL return to IDLE on the next edge with no done pulse, gnt cleared, count set to all-ones and pointer set to owner+1.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 In IDLE, count SHALL hold its last value.
REQ-025 With no request in IDLE, the pointer SHALL be unchanged.

Reset
REQ-026 rst high SHALL immediately force state IDLE, count all-ones (15 at WIDTH=4), gnt 0, done 0, busy 0 and pointer 0, independent of clk.
REQ-027 rst asserted mid-COUNT SHALL drop the countdown with no done pulse.
REQ-028 The first grant after rst release SHALL occur on the first rising edge with rst low and req nonzero.

Configuration
REQ-029 The macro PAUSE_EN SHALL control the pause feature.
REQ-030 With PAUSE_EN defined, pause high in COUNT SHALL hold count and state, and abort SHALL take priority over pause.
REQ-031 With PAUSE_EN defined, pause SHALL have no effect in IDLE or DONE.
REQ-032 Without PAUSE_EN, the pause port SHALL be absent and COUNT SHALL decrement unconditionally.

Verification
REQ-033 Single request: req=0001, load_val[3:0]=3 after rst -> gnt=0001 and count sequence 3,2,1,0; done=0001 for one cycle 4 cycles after the grant; then gnt=0000 and busy=0.
REQ-034 Round robin: req=1111 held, all load values 1 -> grants in order 0001,0010,0100,1000,0001, with each done matching its gnt.
REQ-035 Zero load: req=0100, load_val 0 -> done=0100 one cycle after the grant; count stays 0.
REQ-036 Abort: load 9, abort pulsed while count=5 -> no done, count=15, IDLE next cycle; the next grant goes to the requester after the aborted one.
REQ-037 Reset mid-operation: rst asserted between edges while count=6 -> outputs at reset values before the next clk edge; no done.
REQ-038 PAUSE_EN build: load 4, pause high for 3 cycles at count=2 -> count holds 2 for 3 cycles; done is delayed by 3 cycles; abort during pause -> IDLE next edge.

Source files
------------

// File: rtl/down_timer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : down_timer_scheduler_if
// Brief    : Request/grant/countdown bundle for down_timer_scheduler.
// Revision : 1.0
// ============================================================================
interface down_timer_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;
`ifdef PAUSE_EN
    logic                  pause;

    modport master (
        output req, load_val, abort, pause,
        input  gnt, busy, count, done
    );
    modport slave (
        input  req, load_val, abort, pause,
        output gnt, busy, count, done
    );
`else
    modport master (
        output req, load_val, abort,
        input  gnt, busy, count, done
    );
    modport slave (
        input  req, load_val, abort,
        output gnt, busy, count, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/down_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : down_timer_scheduler
// Brief    : Round-robin arbiter sharing one down counter among NREQ
//            requesters; optional countdown pause enabled by macro PAUSE_EN.
// Revision : 1.0
// ============================================================================
module down_timer_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    down_timer_scheduler_if.slave bus
);
    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_count;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   r_owner;

    logic                 w_found;
    logic [c_ptr_w-1:0]   w_win;
    logic [NREQ-1:0]      w_gnt_oh;
    logic [WIDTH-1:0]     w_load;
    logic                 w_pause;

    // Index arithmetic modulo NREQ; operands are always below NREQ.
    function automatic logic [c_ptr_w-1:0] wrap_add(
        input logic [c_ptr_w-1:0] base,
        input int                 k
    );
        int s;
        s = int'(32'(base)) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[c_ptr_w-1:0];
    endfunction

    // Scan upward from the pointer; the first requesting index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        w_load   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == i[c_ptr_w-1:0]) begin
                w_gnt_oh[i] = w_found;
                w_load      = bus.load_val[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '1;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_COUNT;
                        r_gnt   <= w_gnt_oh;
                        r_owner <= w_win;
                        r_count <= w_load;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    // Abort outranks pause; counter parks at all-ones.
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_count <= '1;
                        r_ptr   <= wrap_add(r_owner, 1);
                    end else if (!w_pause) begin
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= r_gnt;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= wrap_add(r_owner, 1);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_down_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_timer_scheduler
// Brief    : Scenario bench with a done-pulse scoreboard for down_timer_scheduler.
// Revision : 1.0
// ============================================================================
module tb_down_timer_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [NREQ-1:0] exp_q[$];
    logic [NREQ-1:0] sb_exp;

    down_timer_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    down_timer_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Every done pulse must match the next expected owner in order.
    always @(negedge clk) begin
        if (!rst && bus.done !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done: got %b required none", bus.done);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.done !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_done: got %b required %b", bus.done, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req = '0;
        bus.abort = 1'b0;
`ifdef PAUSE_EN
        bus.pause = 1'b0;
`endif
        #4;
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: got %0d outstanding required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (bus.count !== 4'd15 || bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got cnt=%0d gnt=%b done=%b busy=%b required 15/0000/0000/0",
                     bus.count, bus.gnt, bus.done, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (bus.gnt !== 4'b0 || bus.count !== 4'd15 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_hold: got gnt=%b cnt=%0d busy=%b required 0000/15/0",
                     bus.gnt, bus.count, bus.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.load_val = 16'h0003;
        tick();
        total++;
        if (bus.gnt !== 4'b0001 || bus.count !== 4'd3 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: got gnt=%b cnt=%0d busy=%b required 0001/3/1",
                     bus.gnt, bus.count, bus.busy);
        end
        exp_q.push_back(4'b0001);
        bus.req = 4'b1110;
        bus.load_val = 16'hFFFF;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (bus.count !== 4'(3 - i) || bus.done !== 4'b0 || bus.gnt !== 4'b0001) begin
                bad++;
                $display("FAIL single_count: got cnt=%0d done=%b gnt=%b required %0d/0000/0001",
                         bus.count, bus.done, bus.gnt, 3 - i);
            end
        end
        bus.req = 4'b0;
        tick();
        total++;
        if (bus.done !== 4'b0001 || bus.busy !== 1'b1 || bus.count !== 4'd0) begin
            bad++;
            $display("FAIL single_done: got done=%b busy=%b cnt=%0d required 0001/1/0",
                     bus.done, bus.busy, bus.count);
        end
        tick();
        total++;
        if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin
            bad++;
            $display("FAIL single_idle: got gnt=%b busy=%b done=%b required 0000/0/0000",
                     bus.gnt, bus.busy, bus.done);
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] e;
        do_reset();
        bus.req = 4'b1111;
        bus.load_val = 16'h1111;
        for (int g = 0; g < 5; g++) begin
            e = 4'b0001 << (g % 4);
            tick();
            total++;
            if (bus.gnt !== e || bus.count !== 4'd1) begin
                bad++;
                $display("FAIL rr_grant%0d: got gnt=%b cnt=%0d required %b/1", g, bus.gnt, bus.count, e);
            end
            exp_q.push_back(e);
            tick();
            tick();
            total++;
            if (bus.done !== e) begin
                bad++;
                $display("FAIL rr_done%0d: got %b required %b", g, bus.done, e);
            end
            tick();
        end
        bus.req = 4'b0;
        check_drained("rr");
    endtask

    task automatic test_zero_load();
        do_reset();
        bus.req = 4'b0100;
        bus.load_val = 16'h0000;
        tick();
        total++;
        if (bus.gnt !== 4'b0100 || bus.count !== 4'd0) begin
            bad++;
            $display("FAIL zero_grant: got gnt=%b cnt=%0d required 0100/0", bus.gnt, bus.count);
        end
        exp_q.push_back(4'b0100);
        bus.req = 4'b0;
        tick();
        total++;
        if (bus.done !== 4'b0100 || bus.count !== 4'd0) begin
            bad++;
            $display("FAIL zero_done: got done=%b cnt=%0d required 0100/0", bus.done, bus.count);
        end
        tick();
        tick();
        total++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_hold: got cnt=%0d busy=%b required 0/0", bus.count, bus.busy);
        end
        check_drained("zero");
    endtask

    task automatic test_abort();
        do_reset();
        bus.req = 4'b0010;
        bus.load_val = 16'h0090;
        tick();
        bus.req = 4'b0;
        repeat (4) tick();
        total++;
        if (bus.count !== 4'd5) begin
            bad++;
            $display("FAIL abort_pre: got cnt=%0d required 5", bus.count);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.count !== 4'd15 || bus.done !== 4'b0) begin
            bad++;
            $display("FAIL abort_idle: got gnt=%b busy=%b cnt=%0d done=%b required 0000/0/15/0000",
                     bus.gnt, bus.busy, bus.count, bus.done);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.count !== 4'd15 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_idle: got cnt=%0d busy=%b required 15/0", bus.count, bus.busy);
        end
        bus.req = 4'b1011;
        bus.load_val = 16'h2000;
        tick();
        total++;
        if (bus.gnt !== 4'b1000 || bus.count !== 4'd2) begin
            bad++;
            $display("FAIL abort_next_grant: got gnt=%b cnt=%0d required 1000/2", bus.gnt, bus.count);
        end
        exp_q.push_back(4'b1000);
        bus.req = 4'b0;
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.gnt !== 4'b0) begin
            bad++;
            $display("FAIL abort_in_done: got busy=%b cnt=%0d gnt=%b required 0/0/0000",
                     bus.busy, bus.count, bus.gnt);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0001;
        bus.load_val = 16'h0009;
        tick();
        bus.req = 4'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.count !== 4'd15 || bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin
            bad++;
            $display("FAIL rstmid_async: got cnt=%0d gnt=%b busy=%b done=%b required 15/0000/0/0000",
                     bus.count, bus.gnt, bus.busy, bus.done);
        end
        #2;
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.gnt !== 4'b0 || bus.count !== 4'd15) begin
            bad++;
            $display("FAIL rstmid_after: got gnt=%b cnt=%0d required 0000/15", bus.gnt, bus.count);
        end
        check_drained("rstmid");
    endtask

`ifdef PAUSE_EN
    task automatic test_pause();
        do_reset();
        bus.req = 4'b0001;
        bus.load_val = 16'h0004;
        tick();
        exp_q.push_back(4'b0001);
        bus.req = 4'b0;
        tick();
        tick();
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.count !== 4'd2 || bus.done !== 4'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL pause_hold%0d: got cnt=%0d done=%b busy=%b required 2/0000/1",
                         i, bus.count, bus.done, bus.busy);
            end
        end
        bus.pause = 1'b0;
        tick();
        tick();
        total++;
        if (bus.count !== 4'd0 || bus.done !== 4'b0) begin
            bad++;
            $display("FAIL pause_resume: got cnt=%0d done=%b required 0/0000", bus.count, bus.done);
        end
        tick();
        total++;
        if (bus.done !== 4'b0001) begin
            bad++;
            $display("FAIL pause_done: got %b required 0001", bus.done);
        end
        tick();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0;
        bus.pause = 1'b1;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        total++;
        if (bus.gnt !== 4'b0 || bus.count !== 4'd15 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL pause_abort: got gnt=%b cnt=%0d busy=%b required 0000/15/0",
                     bus.gnt, bus.count, bus.busy);
        end
        check_drained("pause");
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.load_val = '0;
        bus.abort = 1'b0;
`ifdef PAUSE_EN
        bus.pause = 1'b0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_zero_load();
        test_abort();
        test_reset_mid();
`ifdef PAUSE_EN
        test_pause();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
